// File: rtl/dw_fifo_s1_sf_pkg.sv
// Shared definitions for the single-clock show-ahead FIFO:
// error-mode encodings and a constant clog2 helper for pointer/count widths.
package dw_fifo_s1_sf_pkg;

  localparam int ERR_STICKY_DIAG = 0;  // sticky, cleared by diag_n
  localparam int ERR_STICKY      = 1;  // sticky until reset
  localparam int ERR_DYNAMIC     = 2;  // one-cycle pulse per fault

  // Smallest r with 2**r >= n; used at elaboration time only.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_s1_sf_ctl.sv
// FIFO control: read/write pointers, occupancy count, status flags and the
// error register. Storage is owned by the top level; this block only says
// when and where to write and where the head entry is.
module fifo_s1_sf_ctl
  import dw_fifo_s1_sf_pkg::*;
#(
  parameter int depth    = 4,
  parameter int ae_level = 1,
  parameter int af_level = 1,
  parameter int err_mode = 0,
  localparam int pw      = clog2(depth),
  localparam int cw      = clog2(depth + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_req_n,
  input  logic          pop_req_n,
  input  logic          diag_n,
  output logic          wr_en,
  output logic [pw-1:0] wr_ptr,
  output logic [pw-1:0] rd_ptr,
  output logic          empty,
  output logic          almost_empty,
  output logic          half_full,
  output logic          almost_full,
  output logic          full,
  output logic          error
);

  localparam logic [pw-1:0] last_ptr = pw'(depth - 1);
  localparam logic [cw-1:0] full_cnt = cw'(depth);
  localparam logic [cw-1:0] ae_cnt   = cw'(ae_level);
  localparam logic [cw-1:0] hf_cnt   = cw'((depth + 1) / 2);
  localparam logic [cw-1:0] af_cnt   = cw'(depth - af_level);

  logic [cw-1:0] count;
  logic          push, pop, do_push, do_pop, fault;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [pw-1:0] next_ptr(input logic [pw-1:0] p);
    return (p == last_ptr) ? '0 : p + pw'(1);
  endfunction

  assign push = ~push_req_n;
  assign pop  = ~pop_req_n;

  // A push into a full FIFO is still accepted when a pop frees the head
  // slot in the same cycle; a pop from an empty FIFO is always dropped.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign fault   = (push & ~pop & full) | (pop & empty);
  assign wr_en   = do_push;

  // Flags decode the registered count only, so requests never reach outputs
  // combinationally.
  assign empty        = (count == '0);
  assign full         = (count == full_cnt);
  assign almost_empty = (count <= ae_cnt);
  assign half_full    = (count >= hf_cnt);
  assign almost_full  = (count >= af_cnt);

  // Pointer and occupancy update.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + cw'(1);
        2'b01:   count <= count - cw'(1);
        default: count <= count;
      endcase
    end
  end

  // Error register: pulse, sticky, or sticky with diagnostic clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      error <= 1'b0;
    end else if (err_mode == ERR_DYNAMIC) begin
      error <= fault;
    end else if (err_mode == ERR_STICKY_DIAG && !diag_n) begin
      error <= 1'b0;
    end else if (fault) begin
      error <= 1'b1;
    end
  end

endmodule

// File: rtl/dw_fifo_s1_sf.sv
// Single-clock synchronous FIFO with show-ahead read data, status flags and
// a configurable error flag. Holds the storage array; control lives in
// fifo_s1_sf_ctl.
module dw_fifo_s1_sf
  import dw_fifo_s1_sf_pkg::*;
#(
  parameter int width    = 8,
  parameter int depth    = 4,
  parameter int ae_level = 1,
  parameter int af_level = 1,
  parameter int err_mode = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_req_n,
  input  logic             pop_req_n,
  input  logic             diag_n,
  input  logic [width-1:0] data_in,
  output logic             empty,
  output logic             almost_empty,
  output logic             half_full,
  output logic             almost_full,
  output logic             full,
  output logic             error,
  output logic [width-1:0] data_out
);

  localparam int pw = clog2(depth);

  logic             wr_en;
  logic [pw-1:0]    wr_ptr, rd_ptr;
  logic [width-1:0] mem [depth];

  fifo_s1_sf_ctl #(
    .depth    (depth),
    .ae_level (ae_level),
    .af_level (af_level),
    .err_mode (err_mode)
  ) u_ctl (
    .clock        (clock),
    .reset        (reset),
    .push_req_n   (push_req_n),
    .pop_req_n    (pop_req_n),
    .diag_n       (diag_n),
    .wr_en        (wr_en),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .empty        (empty),
    .almost_empty (almost_empty),
    .half_full    (half_full),
    .almost_full  (almost_full),
    .full         (full),
    .error        (error)
  );

  // Storage write; cleared on reset so data_out reads 0 out of reset.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: the array is reset deliberately (data_out must be 0 after reset);
    // this forces flops rather than a RAM macro, acceptable at this depth.
    if (reset) begin
      for (int i = 0; i < depth; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Show-ahead: the head entry is always visible.
  assign data_out = mem[rd_ptr];

endmodule

// File: tb/tb_dw_fifo_s1_sf.sv
// Self-checking bench: two DUTs (err_mode 2 and err_mode 0) share one
// stimulus stream; a queue model checks every cycle, and directed literal
// expectations pin the model at the interesting points.
module tb_dw_fifo_s1_sf;

  localparam int W = 32;
  localparam int D = 4;

  logic         clock, reset, push_req_n, pop_req_n, diag_n;
  logic [W-1:0] data_in;

  logic         empty2, ae2, hf2, af2, full2, err2;
  logic [W-1:0] dout2;
  logic         empty0, ae0, hf0, af0, full0, err0;
  logic [W-1:0] dout0;

  int checks = 0;
  int errors = 0;

  dw_fifo_s1_sf #(.width(W), .depth(D), .ae_level(1), .af_level(1), .err_mode(2)) u_dut2 (
    .clock(clock), .reset(reset), .push_req_n(push_req_n), .pop_req_n(pop_req_n),
    .diag_n(diag_n), .data_in(data_in), .empty(empty2), .almost_empty(ae2),
    .half_full(hf2), .almost_full(af2), .full(full2), .error(err2), .data_out(dout2)
  );

  dw_fifo_s1_sf #(.width(W), .depth(D), .ae_level(1), .af_level(1), .err_mode(0)) u_dut0 (
    .clock(clock), .reset(reset), .push_req_n(push_req_n), .pop_req_n(pop_req_n),
    .diag_n(diag_n), .data_in(data_in), .empty(empty0), .almost_empty(ae0),
    .half_full(hf0), .almost_full(af0), .full(full0), .error(err0), .data_out(dout0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  logic [W-1:0] q[$];
  logic         m_err2 = 1'b0;
  logic         m_err0 = 1'b0;

  always begin
    @(posedge clock);
    #1;
    if (reset) begin
      q.delete();
      m_err2 = 1'b0;
      m_err0 = 1'b0;
    end else begin
      automatic bit push  = !push_req_n;
      automatic bit pop   = !pop_req_n;
      automatic int n     = q.size();
      automatic bit fault = (push && !pop && n == D) || (pop && n == 0);
      if (pop && n > 0) void'(q.pop_front());
      if (push && q.size() < D) q.push_back(data_in);
      m_err2 = fault;
      if (!diag_n)    m_err0 = 1'b0;
      else if (fault) m_err0 = 1'b1;
    end
    check_bit("m_empty2", empty2, q.size() == 0);
    check_bit("m_ae2",    ae2,    q.size() <= 1);
    check_bit("m_hf2",    hf2,    q.size() >= 2);
    check_bit("m_af2",    af2,    q.size() >= 3);
    check_bit("m_full2",  full2,  q.size() == D);
    check_bit("m_err2",   err2,   m_err2);
    check_bit("m_empty0", empty0, q.size() == 0);
    check_bit("m_full0",  full0,  q.size() == D);
    check_bit("m_err0",   err0,   m_err0);
    if (q.size() > 0) begin
      check("m_dout2", dout2, q[0]);
      check("m_dout0", dout0, q[0]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input logic pn, input logic qn, input logic [W-1:0] d, input logic dn);
    push_req_n = pn;
    pop_req_n  = qn;
    data_in    = d;
    diag_n     = dn;
    @(negedge clock);
    push_req_n = 1'b1;
    pop_req_n  = 1'b1;
    diag_n     = 1'b1;
  endtask

  task automatic push(input logic [W-1:0] d); cyc(1'b0, 1'b1, d, 1'b1);     endtask
  task automatic pop();                       cyc(1'b1, 1'b0, '0, 1'b1);    endtask
  task automatic idle();                      cyc(1'b1, 1'b1, '0, 1'b1);    endtask
  task automatic both(input logic [W-1:0] d); cyc(1'b0, 1'b0, d, 1'b1);     endtask
  task automatic diag();                      cyc(1'b1, 1'b1, '0, 1'b0);    endtask

  task automatic check_reset_state(input string tag);
    check_bit({tag, "_empty"}, empty2, 1'b1);
    check_bit({tag, "_ae"},    ae2,    1'b1);
    check_bit({tag, "_hf"},    hf2,    1'b0);
    check_bit({tag, "_af"},    af2,    1'b0);
    check_bit({tag, "_full"},  full2,  1'b0);
    check_bit({tag, "_err2"},  err2,   1'b0);
    check_bit({tag, "_err0"},  err0,   1'b0);
    check({tag, "_dout"},      dout2,  32'h0);
  endtask

  initial begin
    reset      = 1'b1;
    push_req_n = 1'b1;
    pop_req_n  = 1'b1;
    diag_n     = 1'b1;
    data_in    = '0;
    repeat (2) @(negedge clock);
    check_reset_state("in_reset");
    reset = 1'b0;
    idle();
    check_reset_state("idle");

    // Fill: flags walk up, head stays A0.
    push(32'hA0);
    check_bit("p1_empty", empty2, 1'b0);
    check_bit("p1_ae", ae2, 1'b1);
    check("p1_dout", dout2, 32'hA0);
    push(32'hA1);
    check_bit("p2_hf", hf2, 1'b1);
    check_bit("p2_ae", ae2, 1'b0);
    push(32'hA2);
    check_bit("p3_af", af2, 1'b1);
    check_bit("p3_full", full2, 1'b0);
    push(32'hA3);
    check_bit("p4_full", full2, 1'b1);
    check("p4_dout", dout2, 32'hA0);

    // Overflow: no change, one-cycle pulse (mode 2), sticky (mode 0).
    push(32'hEE);
    check_bit("ovf_full", full2, 1'b1);
    check("ovf_dout", dout2, 32'hA0);
    check_bit("ovf_err2", err2, 1'b1);
    check_bit("ovf_err0", err0, 1'b1);
    idle();
    check_bit("ovf_err2_clr", err2, 1'b0);
    check_bit("ovf_err0_hold", err0, 1'b1);

    // Drain.
    pop();  check("pop1_dout", dout2, 32'hA1);
    pop();  check("pop2_dout", dout2, 32'hA2);
    pop();  check("pop3_dout", dout2, 32'hA3);
    pop();  check_bit("pop4_empty", empty2, 1'b1);

    // Underflow pulse.
    pop();
    check_bit("udf_err2", err2, 1'b1);
    check_bit("udf_empty", empty2, 1'b1);
    idle();
    check_bit("udf_err2_clr", err2, 1'b0);

    // Simultaneous push+pop while full: write lands in freed slot.
    push(32'hB0); push(32'hB1); push(32'hB2); push(32'hB3);
    both(32'hC0);
    check_bit("pp_full", full2, 1'b1);
    check_bit("pp_err2", err2, 1'b0);
    check("pp_dout", dout2, 32'hB1);
    pop();  check("pp_pop1", dout2, 32'hB2);
    pop();  check("pp_pop2", dout2, 32'hB3);
    pop();  check("pp_pop3", dout2, 32'hC0);
    pop();  check_bit("pp_empty", empty2, 1'b1);

    // Simultaneous push+pop while empty: push wins, underflow flagged.
    both(32'hD0);
    check_bit("pe_empty", empty2, 1'b0);
    check_bit("pe_ae", ae2, 1'b1);
    check("pe_dout", dout2, 32'hD0);
    check_bit("pe_err2", err2, 1'b1);
    idle();
    check_bit("pe_err2_clr", err2, 1'b0);

    // Sticky error with diagnostic clear.
    diag();
    check_bit("diag_clr0", err0, 1'b0);
    pop();
    pop();
    check_bit("st_set0", err0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      idle();
      check_bit("st_hold0", err0, 1'b1);
    end
    diag();
    check_bit("diag_clr1", err0, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0);  // underflow and diag together: clear wins
    check_bit("prio_err0", err0, 1'b0);
    check_bit("prio_err2", err2, 1'b1);

    // Asynchronous reset mid-stream with count = 3.
    push(32'hE0); push(32'hE1); push(32'hE2);
    check_bit("m3_af", af2, 1'b1);
    check_bit("m3_hf", hf2, 1'b1);
    #2 reset = 1'b1;
    #1 check_reset_state("async");
    @(negedge clock);
    reset = 1'b0;
    idle();
    check_reset_state("post");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
